// File: rtl/drive_source_switcher_if.sv
// Bus bundle for drive_source_switcher: time base, switch request, per-source drive data
// and the selected outputs/status.
interface drive_source_switcher_if #(
    parameter int unsigned WIDTH   = 13,
    parameter int unsigned DEPTH   = 249,
    parameter int unsigned NUM_SRC = 2
);
    localparam int unsigned SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [63:0]                             sys_time;
    logic                                    sel_req;
    logic [SW-1:0]                           src_sel;
    logic [NUM_SRC-1:0][DEPTH-1:0][WIDTH-1:0] duty_in;
    logic [NUM_SRC-1:0][DEPTH-1:0][WIDTH-1:0] phase_in;
    logic [DEPTH-1:0][WIDTH-1:0]             duty_out;
    logic [DEPTH-1:0][WIDTH-1:0]             phase_out;
    logic [SW-1:0]                           active_src;
    logic                                    busy;
    logic                                    switched;
    logic                                    sel_err;

    modport master (
        output sys_time, sel_req, src_sel, duty_in, phase_in,
        input  duty_out, phase_out, active_src, busy, switched, sel_err
    );

    modport slave (
        input  sys_time, sel_req, src_sel, duty_in, phase_in,
        output duty_out, phase_out, active_src, busy, switched, sel_err
    );
endinterface

// File: rtl/drive_source_switcher.sv
// Registered N-source drive selector; switches only on SYS_TIME period-wrap boundaries.
// Optional feature macro DRIVE_SW_BLANK_EN adds the BLANK state (duty forced to 0 across the switch).
module drive_source_switcher #(
    parameter int unsigned WIDTH         = 13,
    parameter int unsigned DEPTH         = 249,
    parameter int unsigned NUM_SRC       = 2,
    parameter int unsigned DEFAULT_SRC   = 0,
    parameter int unsigned BOUNDARY_LOG2 = 9,
    parameter int unsigned BLANK_PERIODS = 1
) (
    input logic                    clk_i,
    input logic                    rst_ni,
    drive_source_switcher_if.slave bus_io
);
    localparam int unsigned SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StPending
`ifdef DRIVE_SW_BLANK_EN
        , StBlank
`endif
    } state_e;

    state_e                      state_q, state_d;
    logic [SW-1:0]               active_q, active_d;
    logic [SW-1:0]               target_q, target_d;
    logic [BOUNDARY_LOG2-1:0]    prev_lo_q, lo;
    logic                        switched_q, switched_d;
    logic                        sel_err_q, sel_err_d;
    logic [DEPTH-1:0][WIDTH-1:0] duty_out_q, duty_out_d;
    logic [DEPTH-1:0][WIDTH-1:0] phase_out_q, phase_out_d;
    logic                        bnd, req_valid;
    logic                        unused_time;

`ifdef DRIVE_SW_BLANK_EN
    localparam int unsigned CW = $clog2(BLANK_PERIODS + 1);
    logic [CW-1:0] blank_q, blank_d;
`else
    logic unused_cfg;
    assign unused_cfg = (BLANK_PERIODS == 0);
`endif

    assign unused_time = ^bus_io.sys_time[63:BOUNDARY_LOG2];
    assign lo          = bus_io.sys_time[BOUNDARY_LOG2-1:0];
    // Wrap compare instead of equality so a boundary is still seen if counts are skipped.
    assign bnd         = lo < prev_lo_q;
    assign req_valid   = bus_io.sel_req && (32'(bus_io.src_sel) < NUM_SRC);
    assign sel_err_d   = bus_io.sel_req && !req_valid;

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        active_d   = active_q;
        switched_d = 1'b0;
`ifdef DRIVE_SW_BLANK_EN
        blank_d    = blank_q;
`endif
        unique case (state_q)
            StIdle: begin
                // A boundary in the request cycle is not used; the switch waits for the next one.
                if (req_valid && (bus_io.src_sel != active_q)) begin
                    target_d = bus_io.src_sel;
                    state_d  = StPending;
                end
            end
            StPending: begin
                if (req_valid) target_d = bus_io.src_sel;
                if (req_valid && (bus_io.src_sel == active_q)) begin
                    state_d = StIdle;
                end else if (bnd) begin
`ifdef DRIVE_SW_BLANK_EN
                    state_d = StBlank;
                    blank_d = CW'(BLANK_PERIODS);
`else
                    active_d   = target_d;
                    switched_d = 1'b1;
                    state_d    = StIdle;
`endif
                end
            end
`ifdef DRIVE_SW_BLANK_EN
            StBlank: begin
                if (req_valid) target_d = bus_io.src_sel;
                if (bnd) begin
                    if (blank_q == CW'(1)) begin
                        active_d   = target_d;
                        switched_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        blank_d = blank_q - CW'(1);
                    end
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        duty_out_d  = bus_io.duty_in[active_q];
        phase_out_d = bus_io.phase_in[active_q];
`ifdef DRIVE_SW_BLANK_EN
        // Covers the entry edge and the commit edge so no old/new data leaks around the blank.
        if ((state_q == StBlank) || (state_d == StBlank)) begin
            duty_out_d  = '0;
            phase_out_d = phase_out_q;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            target_q    <= '0;
            active_q    <= SW'(DEFAULT_SRC);
            prev_lo_q   <= '0;
            switched_q  <= 1'b0;
            sel_err_q   <= 1'b0;
            duty_out_q  <= '0;
            phase_out_q <= '0;
`ifdef DRIVE_SW_BLANK_EN
            blank_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            active_q    <= active_d;
            prev_lo_q   <= lo;
            switched_q  <= switched_d;
            sel_err_q   <= sel_err_d;
            duty_out_q  <= duty_out_d;
            phase_out_q <= phase_out_d;
`ifdef DRIVE_SW_BLANK_EN
            blank_q     <= blank_d;
`endif
        end
    end

    assign bus_io.duty_out   = duty_out_q;
    assign bus_io.phase_out  = phase_out_q;
    assign bus_io.active_src = active_q;
    assign bus_io.busy       = (state_q != StIdle);
    assign bus_io.switched   = switched_q;
    assign bus_io.sel_err    = sel_err_q;
endmodule

// File: tb/tb_drive_source_switcher.sv
// Bench for drive_source_switcher: directed vector table, a 3-source request-error sequence,
// and randomized traffic against a boundary-counting reference model.
module tb_drive_source_switcher;
    localparam int W    = 13;
    localparam int D    = 8;
    localparam int BP   = 2;
    localparam int ZERO = 9;
`ifdef DRIVE_SW_BLANK_EN
    localparam int TOTAL = 1 + BP;
`else
    localparam int TOTAL = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    drive_source_switcher_if #(.WIDTH(W), .DEPTH(D), .NUM_SRC(2)) bus ();
    drive_source_switcher_if #(.WIDTH(W), .DEPTH(D), .NUM_SRC(3)) bus3 ();

    drive_source_switcher #(
        .WIDTH(W), .DEPTH(D), .NUM_SRC(2), .DEFAULT_SRC(0), .BOUNDARY_LOG2(9),
        .BLANK_PERIODS(BP)
    ) u_dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus_io(bus)
    );

    drive_source_switcher #(
        .WIDTH(W), .DEPTH(D), .NUM_SRC(3), .DEFAULT_SRC(0), .BOUNDARY_LOG2(9),
        .BLANK_PERIODS(BP)
    ) u_dut3 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus_io(bus3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fixed data pattern: duty = 100*s + k, phase = 300*s + 2k; ZERO selects all-zero.
    function automatic logic [D-1:0][W-1:0] pat(input int s, input bit ph);
        logic [D-1:0][W-1:0] v;
        for (int k = 0; k < D; k++) v[k] = (s == ZERO) ? '0 : W'(ph ? s * 300 + 2 * k : s * 100 + k);
        return v;
    endfunction

    typedef struct {
        bit rst_n; int t; bit req; int sel;
        int act; bit busy; bit sw; int dsrc; int psrc;
    } row_t;
    row_t rows[$];

    task automatic add(input bit r, input int t, input bit q, input int s, input int a,
                       input bit b, input bit w, input int ds, input int ps);
        row_t x;
        x.rst_n = r; x.t = t; x.req = q; x.sel = s;
        x.act = a; x.busy = b; x.sw = w; x.dsrc = ds; x.psrc = ps;
        rows.push_back(x);
    endtask

    task automatic drive3(input bit r, input int t, input bit q, input int s);
        rst_n         = r;
        bus3.sys_time = 64'(t);
        bus3.sel_req  = q;
        bus3.src_sel  = 2'(s);
        tick();
    endtask

    // Reference model: a switch needs TOTAL boundaries; cancel allowed before the first one.
    int                  m_active, m_target, m_wait;
    logic [8:0]          m_prev_lo;
    logic [D-1:0][W-1:0] e_duty, e_phase;
    bit                  e_sw, e_err;

    task automatic model_step();
        logic [8:0] lo;
        bit bnd, valid, was_blank, now_blank;
        int old;
        if (!rst_n) begin
            m_active = 0; m_target = 0; m_wait = 0; m_prev_lo = '0;
            e_duty = '0; e_phase = '0; e_sw = 1'b0; e_err = 1'b0;
            return;
        end
        lo = bus.sys_time[8:0];
        bnd = lo < m_prev_lo;
        m_prev_lo = lo;
        valid = bus.sel_req && (int'(bus.src_sel) < 2);
        e_err = bus.sel_req && !valid;
        was_blank = (m_wait > 0) && (m_wait < TOTAL);
        old = m_active;
        e_sw = 1'b0;
        if (m_wait == 0) begin
            if (valid && int'(bus.src_sel) != m_active) begin
                m_target = int'(bus.src_sel);
                m_wait   = TOTAL;
            end
        end else begin
            if (valid) m_target = int'(bus.src_sel);
            if (valid && m_wait == TOTAL && m_target == m_active) begin
                m_wait = 0;
            end else if (bnd) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_active = m_target;
                    e_sw = 1'b1;
                end
            end
        end
        now_blank = (m_wait > 0) && (m_wait < TOTAL);
        if (was_blank || now_blank) begin
            e_duty = '0;
        end else begin
            e_duty  = bus.duty_in[old];
            e_phase = bus.phase_in[old];
        end
    endtask

    initial begin
        logic [63:0] tv;
        bus.sys_time = '0; bus.sel_req = 1'b0; bus.src_sel = '0;
        bus3.sys_time = '0; bus3.sel_req = 1'b0; bus3.src_sel = '0;
        for (int s = 0; s < 2; s++) begin
            bus.duty_in[s] = pat(s, 1'b0);
            bus.phase_in[s] = pat(s, 1'b1);
        end
        for (int s = 0; s < 3; s++) begin
            bus3.duty_in[s] = pat(s, 1'b0);
            bus3.phase_in[s] = pat(s, 1'b1);
        end

        // rst, time, req, sel | active, busy, switched, duty src, phase src
`ifndef DRIVE_SW_BLANK_EN
        add(0, 0, 0, 0,     0, 0, 0, ZERO, ZERO);
        add(1, 10, 0, 0,    0, 0, 0, 0, 0);
        add(1, 100, 1, 1,   0, 1, 0, 0, 0);
        add(1, 300, 0, 0,   0, 1, 0, 0, 0);
        add(1, 512, 0, 0,   1, 0, 1, 0, 0);
        add(1, 600, 0, 0,   1, 0, 0, 1, 1);
        add(1, 612, 1, 0,   1, 1, 0, 1, 1);
        add(1, 712, 1, 1,   1, 0, 0, 1, 1);
        add(1, 800, 1, 1,   1, 0, 0, 1, 1);
        add(1, 1024, 0, 0,  1, 0, 0, 1, 1);
        add(1, 1500, 1, 0,  1, 1, 0, 1, 1);
        add(1, 1540, 1, 1,  1, 0, 0, 1, 1);
        add(1, 2000, 1, 0,  1, 1, 0, 1, 1);
        add(1, 2050, 1, 0,  0, 0, 1, 1, 1);
        add(1, 2100, 0, 0,  0, 0, 0, 0, 0);
        add(1, 2560, 1, 1,  0, 1, 0, 0, 0);
        add(1, 2600, 0, 0,  0, 1, 0, 0, 0);
        add(0, 2700, 0, 0,  0, 0, 0, ZERO, ZERO);
        add(1, 2800, 0, 0,  0, 0, 0, 0, 0);
        add(1, 3072, 0, 0,  0, 0, 0, 0, 0);
        add(1, 3100, 0, 0,  0, 0, 0, 0, 0);
`else
        add(0, 0, 0, 0,     0, 0, 0, ZERO, ZERO);
        add(1, 10, 0, 0,    0, 0, 0, 0, 0);
        add(1, 100, 1, 1,   0, 1, 0, 0, 0);
        add(1, 512, 0, 0,   0, 1, 0, ZERO, 0);
        add(1, 800, 0, 0,   0, 1, 0, ZERO, 0);
        add(1, 1024, 0, 0,  0, 1, 0, ZERO, 0);
        add(1, 1300, 0, 0,  0, 1, 0, ZERO, 0);
        add(1, 1536, 0, 0,  1, 0, 1, ZERO, 0);
        add(1, 1600, 0, 0,  1, 0, 0, 1, 1);
        add(1, 1700, 1, 0,  1, 1, 0, 1, 1);
        add(1, 2048, 0, 0,  1, 1, 0, ZERO, 1);
        add(1, 2100, 1, 1,  1, 1, 0, ZERO, 1);
        add(1, 2560, 0, 0,  1, 1, 0, ZERO, 1);
        add(1, 2800, 0, 0,  1, 1, 0, ZERO, 1);
        add(1, 3072, 0, 0,  1, 0, 1, ZERO, 1);
        add(1, 3100, 0, 0,  1, 0, 0, 1, 1);
        add(1, 3200, 1, 0,  1, 1, 0, 1, 1);
        add(0, 3300, 0, 0,  0, 0, 0, ZERO, ZERO);
        add(1, 3400, 0, 0,  0, 0, 0, 0, 0);
        add(1, 3584, 0, 0,  0, 0, 0, 0, 0);
`endif
        foreach (rows[i]) begin
            rst_n        = rows[i].rst_n;
            bus.sys_time = 64'(rows[i].t);
            bus.sel_req  = rows[i].req;
            bus.src_sel  = 1'(rows[i].sel);
            tick();
            chk($sformatf("row%0d active", i), bus.active_src, rows[i].act);
            chk($sformatf("row%0d busy", i), bus.busy, rows[i].busy);
            chk($sformatf("row%0d switched", i), bus.switched, rows[i].sw);
            chk($sformatf("row%0d sel_err", i), bus.sel_err, 0);
            chk($sformatf("row%0d duty", i), bus.duty_out, pat(rows[i].dsrc, 1'b0));
            chk($sformatf("row%0d phase", i), bus.phase_out, pat(rows[i].psrc, 1'b1));
        end
        bus.sel_req = 1'b0;

        // Three sources: out-of-range select and retarget at the boundary.
        drive3(0, 0, 0, 0);
        chk("s3 reset sel_err", bus3.sel_err, 0);
        chk("s3 reset busy", bus3.busy, 0);
        drive3(1, 10, 0, 0);
        drive3(1, 100, 1, 3);
        chk("s3 err pulse", bus3.sel_err, 1);
        chk("s3 err busy", bus3.busy, 0);
        chk("s3 err active", bus3.active_src, 0);
        drive3(1, 150, 0, 0);
        chk("s3 err cleared", bus3.sel_err, 0);
        drive3(1, 200, 1, 2);
        chk("s3 req2 busy", bus3.busy, 1);
        drive3(1, 250, 1, 3);
        chk("s3 err in pending", bus3.sel_err, 1);
        chk("s3 pending kept", bus3.busy, 1);
        drive3(1, 512, 1, 1);
        drive3(1, 700, 0, 0);
        drive3(1, 1024, 0, 0);
        drive3(1, 1200, 0, 0);
        drive3(1, 1536, 0, 0);
        drive3(1, 1700, 0, 0);
        drive3(1, 2048, 0, 0);
        chk("s3 retarget active", bus3.active_src, 1);
        chk("s3 retarget busy", bus3.busy, 0);
        chk("s3 retarget duty", bus3.duty_out, pat(1, 1'b0));

        // Randomized traffic against the model.
        tv = 64'd5;
        for (int c = 0; c < 2500; c++) begin
            rst_n = (c < 2) ? 1'b0 : ($urandom_range(0, 299) != 0);
            for (int s = 0; s < 2; s++) begin
                for (int k = 0; k < D; k++) begin
                    bus.duty_in[s][k]  = W'($urandom);
                    bus.phase_in[s][k] = W'($urandom);
                end
            end
            if ($urandom_range(0, 9) == 0) tv = tv + 64'($urandom_range(300, 1500));
            else tv = tv + 64'($urandom_range(1, 60));
            bus.sys_time = tv;
            bus.sel_req  = ($urandom_range(0, 4) == 0);
            bus.src_sel  = 1'($urandom_range(0, 1));
            model_step();
            tick();
            chk("rnd active", bus.active_src, m_active);
            chk("rnd busy", bus.busy, m_wait != 0);
            chk("rnd switched", bus.switched, e_sw);
            chk("rnd sel_err", bus.sel_err, e_err);
            chk("rnd duty", bus.duty_out, e_duty);
            chk("rnd phase", bus.phase_out, e_phase);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
